// File: rtl/dram_req_arbiter.sv
// -----------------------------------------------------------------------------
// dram_req_arbiter
//
// Merges NUM_CH core-side DRAM request ports onto the single DRAM controller
// request/response port. Round-robin arbitration with one outstanding
// transaction at a time. Sits in the sys_clk domain.
//
// FSM: IDLE -> BUSY -> GAP -> IDLE. The GAP cycle ignores all ch_valid inputs
// so the channel that just completed has time to drop its request.
//
// Optional feature (compile-time macro DRAM_ARB_TIMEOUT_EN):
//   When defined, a watchdog aborts a BUSY transaction after TIMEOUT_CYCLES
//   cycles without res_ready, pulsing ch_ready and ch_err together with
//   ch_dout forced to all ones. When undefined, no counter exists, ch_err is
//   held at 0 and BUSY waits for res_ready indefinitely.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   ch_addr    per-channel address, channel i at [i*ADDR_W +: ADDR_W]
//   ch_din     per-channel write data, channel i at [i*DATA_W +: DATA_W]
//   ch_rw      per-channel direction (1 = write, 0 = read)
//   ch_valid   per-channel request level
//   ch_dout    read data shared by all channels, qualified by ch_ready
//   ch_ready   per-channel one-cycle completion pulse
//   ch_err     per-channel timeout pulse, coincident with ch_ready
//   req_addr   address to the DRAM controller
//   req_data   write data to the DRAM controller
//   req_rw     direction to the DRAM controller
//   req_valid  request level to the DRAM controller
//   res_data   controller read data
//   res_ready  controller completion pulse
//   grant_id   channel currently or last granted
//   busy       high in every state except IDLE
// -----------------------------------------------------------------------------
module dram_req_arbiter #(
    parameter int NUM_CH         = 2,
    parameter int ADDR_W         = 27,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_CH*ADDR_W-1:0]                  ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]                  ch_din,
    input  logic [NUM_CH-1:0]                         ch_rw,
    input  logic [NUM_CH-1:0]                         ch_valid,
    output logic [DATA_W-1:0]                         ch_dout,
    output logic [NUM_CH-1:0]                         ch_ready,
    output logic [NUM_CH-1:0]                         ch_err,
    output logic [ADDR_W-1:0]                         req_addr,
    output logic [DATA_W-1:0]                         req_data,
    output logic                                      req_rw,
    output logic                                      req_valid,
    input  logic [DATA_W-1:0]                         res_data,
    input  logic                                      res_ready,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] grant_id,
    output logic                                      busy
);

    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [GW-1:0]       rr_ptr_r;
    logic [GW-1:0]       rr_ptr_nxt_s;
    logic [GW-1:0]       grant_id_r;
    logic [GW-1:0]       grant_id_nxt_s;
    logic [ADDR_W-1:0]   req_addr_r;
    logic [ADDR_W-1:0]   req_addr_nxt_s;
    logic [DATA_W-1:0]   req_data_r;
    logic [DATA_W-1:0]   req_data_nxt_s;
    logic                req_rw_r;
    logic                req_rw_nxt_s;
    logic                req_valid_r;
    logic                req_valid_nxt_s;
    logic [DATA_W-1:0]   ch_dout_r;
    logic [DATA_W-1:0]   ch_dout_nxt_s;
    logic [NUM_CH-1:0]   ch_ready_r;
    logic [NUM_CH-1:0]   ch_ready_nxt_s;
    logic [NUM_CH-1:0]   ch_err_r;
    logic [NUM_CH-1:0]   ch_err_nxt_s;
    logic                busy_r;

    logic [GW-1:0]       win_s;
    logic                any_s;
    logic                timeout_s;

`ifdef DRAM_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0]     wd_cnt_r;

    // Watchdog: held at zero outside BUSY so it starts from zero on every BUSY entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_r <= '0;
        end else if (state_r == ST_BUSY) begin
            wd_cnt_r <= wd_cnt_r + 1'b1;
        end else begin
            wd_cnt_r <= '0;
        end
    end

    // The counter reads TIMEOUT_CYCLES-1 during the TIMEOUT_CYCLES-th BUSY cycle;
    // a res_ready in that same cycle takes priority over the abort.
    assign timeout_s = (state_r == ST_BUSY) && !res_ready &&
                       (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Round-robin search: first requesting channel after rr_ptr, with wrap.
    always_comb begin
        int idx_v;
        win_s = rr_ptr_r;
        any_s = 1'b0;
        idx_v = 0;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx_v = (int'(rr_ptr_r) + off) % NUM_CH;
            if (!any_s && ch_valid[idx_v]) begin
                any_s = 1'b1;
                win_s = GW'(idx_v);
            end else begin
                any_s = any_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (res_ready || timeout_s) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_GAP:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: next values for every registered output; pulses default low.
    always_comb begin
        rr_ptr_nxt_s    = rr_ptr_r;
        grant_id_nxt_s  = grant_id_r;
        req_addr_nxt_s  = req_addr_r;
        req_data_nxt_s  = req_data_r;
        req_rw_nxt_s    = req_rw_r;
        req_valid_nxt_s = req_valid_r;
        ch_dout_nxt_s   = ch_dout_r;
        ch_ready_nxt_s  = '0;
        ch_err_nxt_s    = '0;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    rr_ptr_nxt_s    = win_s;
                    grant_id_nxt_s  = win_s;
                    req_addr_nxt_s  = ch_addr[int'(win_s)*ADDR_W +: ADDR_W];
                    req_data_nxt_s  = ch_din[int'(win_s)*DATA_W +: DATA_W];
                    req_rw_nxt_s    = ch_rw[win_s];
                    req_valid_nxt_s = 1'b1;
                end else begin
                    req_valid_nxt_s = 1'b0;
                end
            end
            ST_BUSY: begin
                if (res_ready) begin
                    req_valid_nxt_s = 1'b0;
                    ch_ready_nxt_s  = NUM_CH'(1'b1) << grant_id_r;
                    if (req_rw_r == 1'b0) begin
                        ch_dout_nxt_s = res_data;
                    end else begin
                        ch_dout_nxt_s = ch_dout_r;
                    end
                end else if (timeout_s) begin
                    req_valid_nxt_s = 1'b0;
                    ch_ready_nxt_s  = NUM_CH'(1'b1) << grant_id_r;
                    ch_err_nxt_s    = NUM_CH'(1'b1) << grant_id_r;
                    ch_dout_nxt_s   = {DATA_W{1'b1}};
                end else begin
                    req_valid_nxt_s = 1'b1;
                end
            end
            ST_GAP: begin
                req_valid_nxt_s = 1'b0;
            end
            default: begin
                req_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Output and arbitration-pointer registers; rr_ptr resets so channel 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r    <= GW'(NUM_CH - 1);
            grant_id_r  <= '0;
            req_addr_r  <= '0;
            req_data_r  <= '0;
            req_rw_r    <= 1'b0;
            req_valid_r <= 1'b0;
            ch_dout_r   <= '0;
            ch_ready_r  <= '0;
            ch_err_r    <= '0;
            busy_r      <= 1'b0;
        end else begin
            rr_ptr_r    <= rr_ptr_nxt_s;
            grant_id_r  <= grant_id_nxt_s;
            req_addr_r  <= req_addr_nxt_s;
            req_data_r  <= req_data_nxt_s;
            req_rw_r    <= req_rw_nxt_s;
            req_valid_r <= req_valid_nxt_s;
            ch_dout_r   <= ch_dout_nxt_s;
            ch_ready_r  <= ch_ready_nxt_s;
            ch_err_r    <= ch_err_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    assign grant_id  = grant_id_r;
    assign req_addr  = req_addr_r;
    assign req_data  = req_data_r;
    assign req_rw    = req_rw_r;
    assign req_valid = req_valid_r;
    assign ch_dout   = ch_dout_r;
    assign ch_ready  = ch_ready_r;
    assign ch_err    = ch_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dram_req_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for dram_req_arbiter with four channels. A table of transactions
// (request mask, directions, controller response, latency, expected grant and
// expected ch_dout) drives the main checks; hand-written sequences cover
// res_ready outside BUSY, valid dropping mid-transaction, reset mid-transaction
// and, when DRAM_ARB_TIMEOUT_EN is defined, the watchdog abort.
// -----------------------------------------------------------------------------
module tb_dram_req_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 27;
    localparam int DW  = 32;
`ifdef DRAM_ARB_TIMEOUT_EN
    localparam int TO  = 16;
`else
    localparam int TO  = 1023;
`endif

    logic                clk;
    logic                rst;
    logic [NCH*AW-1:0]   ch_addr;
    logic [NCH*DW-1:0]   ch_din;
    logic [NCH-1:0]      ch_rw;
    logic [NCH-1:0]      ch_valid;
    logic [DW-1:0]       ch_dout;
    logic [NCH-1:0]      ch_ready;
    logic [NCH-1:0]      ch_err;
    logic [AW-1:0]       req_addr;
    logic [DW-1:0]       req_data;
    logic                req_rw;
    logic                req_valid;
    logic [DW-1:0]       res_data;
    logic                res_ready;
    logic [1:0]          grant_id;
    logic                busy;

    dram_req_arbiter #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_addr(ch_addr), .ch_din(ch_din), .ch_rw(ch_rw), .ch_valid(ch_valid),
        .ch_dout(ch_dout), .ch_ready(ch_ready), .ch_err(ch_err),
        .req_addr(req_addr), .req_data(req_data), .req_rw(req_rw),
        .req_valid(req_valid), .res_data(res_data), .res_ready(res_ready),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  rw;
        logic [31:0] rdata;
        int          lat;
        int          exp_g;
        logic [31:0] exp_dout;
    } vec_t;

    logic [AW-1:0] addr_tab [NCH];
    logic [DW-1:0] din_tab  [NCH];
    vec_t          vecs     [15];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait (bounded) for req_valid after presenting a request from IDLE.
    task automatic wait_grant(output int waited);
        waited = 0;
        while (waited < 20) begin
            @(negedge clk);
            waited++;
            if (req_valid) break;
        end
    endtask

    // One complete transaction with all checks, ending back in IDLE.
    task automatic run_txn(input vec_t v);
        int waited;
        logic [3:0] onehot;
        ch_valid = v.mask;
        ch_rw    = v.rw;
        wait_grant(waited);
        chk("grant_latency", 32'(waited), 32'd1);
        if (!req_valid) return;
        chk("grant_id", 32'(grant_id), 32'(v.exp_g));
        chk("req_addr", 32'(req_addr), 32'(addr_tab[v.exp_g]));
        chk("req_rw", 32'(req_rw), 32'(v.rw[v.exp_g]));
        if (v.rw[v.exp_g]) chk("req_data", req_data, din_tab[v.exp_g]);
        chk("busy_in_busy", 32'(busy), 32'd1);
        for (int c = 0; c < v.lat; c++) begin
            @(negedge clk);
            chk("no_early_ready", 32'(ch_ready), 32'd0);
            chk("req_valid_held", 32'(req_valid), 32'd1);
        end
        res_ready = 1'b1;
        res_data  = v.rdata;
        @(negedge clk);
        res_ready = 1'b0;
        res_data  = 32'hBAD0_BAD0;
        onehot = 4'b0001 << v.exp_g;
        chk("ch_ready_pulse", 32'(ch_ready), 32'(onehot));
        chk("ch_dout", ch_dout, v.exp_dout);
        chk("req_valid_drop", 32'(req_valid), 32'd0);
        chk("ch_err_zero", 32'(ch_err), 32'd0);
        chk("busy_in_gap", 32'(busy), 32'd1);
        @(negedge clk);
        chk("ready_one_cycle", 32'(ch_ready), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int waited;
        addr_tab[0] = 27'h0000100; addr_tab[1] = 27'h0000200;
        addr_tab[2] = 27'h0000300; addr_tab[3] = 27'h0000400;
        din_tab[0]  = 32'hA0A0_A0A0; din_tab[1] = 32'h1234_5678;
        din_tab[2]  = 32'h0BAD_F00D; din_tab[3] = 32'hC0FF_EE00;

        //          mask     rw       rdata          lat g  expected dout
        vecs[0]  = '{4'b0001, 4'b0000, 32'hDEAD_BEEF, 2, 0, 32'hDEAD_BEEF}; // single read
        vecs[1]  = '{4'b0010, 4'b0010, 32'h5555_5555, 3, 1, 32'hDEAD_BEEF}; // write keeps dout
        vecs[2]  = '{4'b0011, 4'b0000, 32'h1111_0000, 5, 0, 32'h1111_0000}; // contention 0,1
        vecs[3]  = '{4'b0011, 4'b0000, 32'h2222_0001, 5, 1, 32'h2222_0001};
        vecs[4]  = '{4'b0011, 4'b0000, 32'h3333_0002, 5, 0, 32'h3333_0002};
        vecs[5]  = '{4'b0011, 4'b0000, 32'h4444_0003, 5, 1, 32'h4444_0003};
        vecs[6]  = '{4'b1100, 4'b0000, 32'h5555_0004, 2, 2, 32'h5555_0004}; // rotation 2,3
        vecs[7]  = '{4'b1100, 4'b0000, 32'h6666_0005, 2, 3, 32'h6666_0005};
        vecs[8]  = '{4'b1100, 4'b0000, 32'h7777_0006, 2, 2, 32'h7777_0006};
        vecs[9]  = '{4'b1100, 4'b0000, 32'h8888_0007, 2, 3, 32'h8888_0007};
        vecs[10] = '{4'b1111, 4'b0101, 32'h9999_9999, 1, 0, 32'h8888_0007}; // all request
        vecs[11] = '{4'b1111, 4'b0101, 32'h0A0A_0A0A, 1, 1, 32'h0A0A_0A0A};
        vecs[12] = '{4'b1111, 4'b0101, 32'h0B0B_0B0B, 0, 2, 32'h0A0A_0A0A};
        vecs[13] = '{4'b1111, 4'b0101, 32'h0C0C_0C0C, 1, 3, 32'h0C0C_0C0C};
        vecs[14] = '{4'b0110, 4'b0000, 32'h0D0D_0D0D, 3, 1, 32'h0D0D_0D0D}; // wrap from 3

        rst = 1'b1; ch_valid = '0; ch_rw = '0; res_ready = 1'b0; res_data = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_addr[i*AW +: AW] = addr_tab[i];
            ch_din[i*DW +: DW]  = din_tab[i];
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ch_ready", 32'(ch_ready), 32'd0);
        chk("rst_ch_dout", ch_dout, 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_req_addr", 32'(req_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) run_txn(vecs[i]);
        ch_valid = '0;

        // res_ready while IDLE is ignored
        @(negedge clk);
        res_ready = 1'b1; res_data = 32'h7777_7777;
        @(negedge clk);
        res_ready = 1'b0;
        chk("idle_res_no_ready", 32'(ch_ready), 32'd0);
        chk("idle_res_busy", 32'(busy), 32'd0);
        chk("idle_res_dout", ch_dout, 32'h0D0D_0D0D);
        @(negedge clk);
        chk("idle_res_no_ready2", 32'(ch_ready), 32'd0);

        // ch_valid falling during BUSY still completes (rr_ptr=1 -> ch0 wins)
        ch_valid = 4'b0001; ch_rw = 4'b0000;
        wait_grant(waited);
        chk("drop_grant", 32'(grant_id), 32'd0);
        ch_valid = 4'b0000;
        repeat (2) @(negedge clk);
        chk("drop_still_valid", 32'(req_valid), 32'd1);
        res_ready = 1'b1; res_data = 32'h0E0E_0E0E;
        @(negedge clk);
        res_ready = 1'b0;
        chk("drop_ready", 32'(ch_ready), 32'b0001);
        chk("drop_dout", ch_dout, 32'h0E0E_0E0E);
        @(negedge clk);

        // Reset mid-transaction (rr_ptr=0 -> ch1 wins)
        ch_valid = 4'b0010;
        wait_grant(waited);
        chk("mid_grant", 32'(grant_id), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_req_valid", 32'(req_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(ch_ready), 32'd0);
        @(negedge clk);
        chk("mid_rst_dout", ch_dout, 32'd0);
        rst = 1'b0;
        ch_valid = 4'b0000;
        @(negedge clk);
        chk("post_rst_no_ready", 32'(ch_ready), 32'd0);
        run_txn('{4'b0011, 4'b0000, 32'h0F0F_0F0F, 2, 0, 32'h0F0F_0F0F});
        ch_valid = '0;

`ifdef DRAM_ARB_TIMEOUT_EN
        // Watchdog abort: controller never answers (rr_ptr=0 -> ch2 wins)
        ch_valid = 4'b0100;
        wait_grant(waited);
        chk("to_grant", 32'(grant_id), 32'd2);
        for (int c = 0; c < TO - 1; c++) begin
            @(negedge clk);
            chk("to_no_early_ready", 32'(ch_ready), 32'd0);
        end
        @(negedge clk);
        chk("to_ready", 32'(ch_ready), 32'b0100);
        chk("to_err", 32'(ch_err), 32'b0100);
        chk("to_dout", ch_dout, 32'hFFFF_FFFF);
        chk("to_req_valid", 32'(req_valid), 32'd0);
        ch_valid = 4'b0000;
        @(negedge clk);
        chk("to_err_pulse", 32'(ch_err), 32'd0);
`endif

        // Later normal transaction completes without error
        run_txn('{4'b1000, 4'b0000, 32'h1357_9BDF, 4, 3, 32'h1357_9BDF});
        ch_valid = '0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound on simulation time
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
